// File: rtl/trig_param_bank.sv
// rtl/trig_param_bank.sv - trigger-loaded parameter register bank with immediate or staged commit
module trig_param_bank #(
   parameter int                   NUM_CH   = 16,
   parameter logic [NUM_CH*32-1:0] DEFAULTS = {NUM_CH{32'h0}},
   parameter int                   SELW     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    trig,
   input  logic [15:0]          wire_lo,
   input  logic [15:0]          wire_hi,
   input  logic                 mode,
   input  logic                 commit_tick,
   input  logic [SELW-1:0]      rd_sel,
   output logic [NUM_CH*32-1:0] params_out,
   output logic [NUM_CH-1:0]    pending,
   output logic                 update_strobe,
   output logic [15:0]          load_cnt,
   output logic [31:0]          rd_data
);

   logic [31:0]       live_q    [NUM_CH];
   logic [31:0]       live_d    [NUM_CH];
   logic [31:0]       staging_q [NUM_CH];
   logic [31:0]       staging_d [NUM_CH];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] trig_prev_q, trig_prev_d;
   logic              update_strobe_q, update_strobe_d;
   logic [15:0]       load_cnt_q, load_cnt_d;
   logic [31:0]       rd_data_q, rd_data_d;

   logic [NUM_CH-1:0] load_evt;
   logic [31:0]       load_word;
   logic              commit;
   logic              live_wr;

   // Per-channel next state: edge detect, staging, commit/flush into live, counters and readback
   always_comb begin
      load_evt        = trig & ~trig_prev_q;
      load_word       = {wire_hi, wire_lo};
      commit          = mode & commit_tick;
      trig_prev_d     = trig;
      live_wr         = 1'b0;
      pending_d       = pending_q;
      rd_data_d       = 32'h0;
      for (int k = 0; k < NUM_CH; k++) begin
         staging_d[k] = staging_q[k];
         live_d[k]    = live_q[k];
         if (!mode) begin
            // Leaving deferred mode flushes anything still staged; a same-cycle load lands on top.
            if (pending_q[k]) begin
               live_d[k] = staging_q[k];
               live_wr   = 1'b1;
            end
            pending_d[k] = 1'b0;
            if (load_evt[k]) begin
               staging_d[k] = load_word;
               live_d[k]    = load_word;
               live_wr      = 1'b1;
            end
         end else begin
            if (load_evt[k]) begin
               staging_d[k] = load_word;
            end
            if (commit) begin
               if (pending_q[k]) begin
                  live_d[k] = staging_q[k];
                  live_wr   = 1'b1;
               end
               // A load arriving with the tick joins this commit rather than waiting for the next.
               if (load_evt[k]) begin
                  live_d[k] = load_word;
                  live_wr   = 1'b1;
               end
               pending_d[k] = 1'b0;
            end else if (load_evt[k]) begin
               pending_d[k] = 1'b1;
            end
         end
         if (rd_sel == SELW'(k)) begin
            rd_data_d = live_q[k];
         end
      end
      update_strobe_d = live_wr;
      load_cnt_d      = load_cnt_q + {15'h0, |load_evt};
   end

   // State registers with synchronous reset to defaults
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            live_q[k]    <= DEFAULTS[k*32 +: 32];
            staging_q[k] <= DEFAULTS[k*32 +: 32];
         end
         pending_q       <= '0;
         trig_prev_q     <= '1;
         update_strobe_q <= 1'b0;
         load_cnt_q      <= 16'h0;
         rd_data_q       <= 32'h0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            live_q[k]    <= live_d[k];
            staging_q[k] <= staging_d[k];
         end
         pending_q       <= pending_d;
         trig_prev_q     <= trig_prev_d;
         update_strobe_q <= update_strobe_d;
         load_cnt_q      <= load_cnt_d;
         rd_data_q       <= rd_data_d;
      end
   end

   // Flatten live registers onto the output bus
   always_comb begin
      params_out = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         params_out[k*32 +: 32] = live_q[k];
      end
   end

   assign pending       = pending_q;
   assign update_strobe = update_strobe_q;
   assign load_cnt      = load_cnt_q;
   assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_trig_param_bank.sv
// tb/tb_trig_param_bank.sv - directed self-checking bench for trig_param_bank
module tb_trig_param_bank;

   localparam int          NUM_CH = 16;
   localparam int          SELW   = 5;
   localparam logic [511:0] TB_DEF = (512'h42A0_0000 << 128) | 512'h3F66_6666;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_CH-1:0]    trig;
   logic [15:0]          wire_lo, wire_hi;
   logic                 mode, commit_tick;
   logic [SELW-1:0]      rd_sel;
   logic [NUM_CH*32-1:0] params_out;
   logic [NUM_CH-1:0]    pending;
   logic                 update_strobe;
   logic [15:0]          load_cnt;
   logic [31:0]          rd_data;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_cnt;
   int          phase;

   trig_param_bank #(.NUM_CH(NUM_CH), .DEFAULTS(TB_DEF), .SELW(SELW)) dut (
      .clk(clk), .reset(reset), .trig(trig), .wire_lo(wire_lo), .wire_hi(wire_hi),
      .mode(mode), .commit_tick(commit_tick), .rd_sel(rd_sel), .params_out(params_out),
      .pending(pending), .update_strobe(update_strobe), .load_cnt(load_cnt), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ch(input int k);
      return params_out[k*32 +: 32];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_word(input logic [31:0] w);
      wire_hi = w[31:16];
      wire_lo = w[15:0];
   endtask

   initial begin
      reset = 1'b1; trig = 16'h0080; mode = 1'b0; commit_tick = 1'b0;
      rd_sel = 5'd15; set_word(32'hAAAA_5555);
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_ch0", ch(0), 32'h3F66_6666);
      chk("rst_ch4", ch(4), 32'h42A0_0000);
      chk("rst_ch7_held_trig", ch(7), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_load_cnt", 32'(load_cnt), 32'h0);
      chk("rst_strobe", 32'(update_strobe), 32'h0);
      chk("rst_rd_data", rd_data, 32'h0);
      trig = 16'h0; tick();

      // Immediate load on ch15
      set_word(32'h3E71_4120); trig = 16'h8000;
      tick();
      chk("imm_ch15", ch(15), 32'h3E71_4120);
      chk("imm_strobe", 32'(update_strobe), 32'h1);
      chk("imm_load_cnt", 32'(load_cnt), 32'h1);
      chk("imm_pending", 32'(pending), 32'h0);
      tick();
      chk("imm_strobe_drop", 32'(update_strobe), 32'h0);
      chk("imm_rd_data", rd_data, 32'h3E71_4120);
      for (int i = 0; i < 9; i++) tick();
      chk("imm_held_load_cnt", 32'(load_cnt), 32'h1);
      trig = 16'h0; tick();

      // Deferred loads: ch1 twice, ch2 once
      mode = 1'b1;
      set_word(32'h1); trig = 16'h0002; tick(); trig = 16'h0; tick();
      set_word(32'h2); trig = 16'h0002; tick(); trig = 16'h0; tick();
      set_word(32'h3); trig = 16'h0004; tick();
      chk("def_strobe_none", 32'(update_strobe), 32'h0);
      trig = 16'h0; tick();
      chk("def_ch1_live", ch(1), 32'h0);
      chk("def_ch2_live", ch(2), 32'h0);
      chk("def_pending", 32'(pending), 32'h0006);
      chk("def_load_cnt", 32'(load_cnt), 32'h4);
      commit_tick = 1'b1; tick();
      chk("commit_ch1", ch(1), 32'h2);
      chk("commit_ch2", ch(2), 32'h3);
      chk("commit_pending", 32'(pending), 32'h0);
      chk("commit_strobe", 32'(update_strobe), 32'h1);
      commit_tick = 1'b0; tick();
      chk("commit_strobe_drop", 32'(update_strobe), 32'h0);

      // Load and commit in the same cycle
      set_word(32'hDEAD_BEEF); trig = 16'h0008; commit_tick = 1'b1; tick();
      chk("same_ch3", ch(3), 32'hDEAD_BEEF);
      chk("same_pending", 32'(pending), 32'h0);
      chk("same_strobe", 32'(update_strobe), 32'h1);
      chk("same_load_cnt", 32'(load_cnt), 32'h5);
      trig = 16'h0; commit_tick = 1'b0; tick();

      // Stage ch5 then flush by returning to immediate mode
      set_word(32'h55); trig = 16'h0020; tick();
      chk("flush_staged_pending", 32'(pending), 32'h0020);
      chk("flush_staged_live", ch(5), 32'h0);
      trig = 16'h0; mode = 1'b0; tick();
      chk("flush_ch5", ch(5), 32'h55);
      chk("flush_pending", 32'(pending), 32'h0);
      chk("flush_strobe", 32'(update_strobe), 32'h1);
      commit_tick = 1'b1; tick();
      commit_tick = 1'b0; tick();
      chk("idle_commit_m0_strobe", 32'(update_strobe), 32'h0);
      mode = 1'b1; commit_tick = 1'b1; tick();
      commit_tick = 1'b0; tick();
      chk("idle_commit_m1_strobe", 32'(update_strobe), 32'h0);
      mode = 1'b0;

      // Readback select range
      rd_sel = 5'd16; tick();
      chk("rd_out_of_range", rd_data, 32'h0);
      rd_sel = 5'd4; tick();
      chk("rd_ch4", rd_data, 32'h42A0_0000);

      // Load counter wrap: alternate ch8/ch9 so every cycle carries an edge
      exp_cnt = 16'h6;
      chk("wrap_start_cnt", 32'(load_cnt), 32'(exp_cnt));
      set_word(32'h0BAD_F00D);
      phase = 0;
      while (exp_cnt != 16'hFFFF) begin
         trig = (phase == 0) ? 16'h0100 : 16'h0200;
         phase = 1 - phase;
         tick();
         exp_cnt = exp_cnt + 16'h1;
      end
      chk("wrap_ffff", 32'(load_cnt), 32'h0000_FFFF);
      trig = (phase == 0) ? 16'h0100 : 16'h0200;
      tick();
      chk("wrap_zero", 32'(load_cnt), 32'h0);
      chk("wrap_ch8", ch(8), 32'h0BAD_F00D);
      trig = 16'h0; tick();

      // Reset during deferral discards staging
      mode = 1'b1; set_word(32'h1234); trig = 16'h0001; tick();
      chk("mid_def_pending", 32'(pending), 32'h0001);
      trig = 16'h0; reset = 1'b1; tick();
      reset = 1'b0; commit_tick = 1'b1; tick();
      chk("mid_def_ch0", ch(0), 32'h3F66_6666);
      chk("mid_def_pending_clr", 32'(pending), 32'h0);
      chk("mid_def_strobe", 32'(update_strobe), 32'h0);
      commit_tick = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
